// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the GPIO LED sequencer.
// Register map, display modes and CTRL field offsets.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_PWM    = 2'd3
    } mode_e;

    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_MODE_W   = 2;
    localparam int CTRL_DUTY_LSB = 2;

    localparam logic PHASE_ON  = 1'b1;
    localparam logic PHASE_OFF = 1'b0;

endpackage

// File: rtl/led_prescaler.sv
// Free-running tick generator for the LED sequencer.
// A period of 0 or 1 ticks on every clock.
module led_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic [W-1:0] last;
    logic         hit;

    assign last = (period == '0) ? '0 : period - 1'b1;
    assign hit  = (cnt == last);
    assign tick = hit & ~clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || hit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped LED bank sequencer: static, blink, chase, PWM dim.
// PWM mode is built only when LED_PWM_EN is defined.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int          NLED           = 8,
    parameter logic [15:0] DEFAULT_PERIOD = 16'd50000,
    parameter int          PWM_BITS       = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [1:0]      addr,
    input  logic [15:0]     in,
    output logic [15:0]     out,
    output logic [NLED-1:0] led
);

    logic [15:0]         pattern;
    logic [15:0]         period;
    logic [PWM_BITS-1:0] duty;
    mode_e               mode;
    mode_e               mode_nx;
    logic                phase;
    logic                phase_nx;
    logic [NLED-1:0]     chase;
    logic [NLED-1:0]     chase_nx;
    logic [NLED-1:0]     led_nx;
    logic [NLED-1:0]     pat_led;
    logic [NLED:0]       status;
    logic                tick;
    logic                tick_ok;
    logic                wr_pat;
    logic                wr_ctrl;
    logic                wr_per;
    logic                any_wr;
    logic                mode_chg;
    logic                unused_pat_hi;

    assign wr_pat   = load && (addr == ADDR_PATTERN);
    assign wr_ctrl  = load && (addr == ADDR_CTRL);
    assign wr_per   = load && (addr == ADDR_PERIOD);
    assign any_wr   = load && (addr != ADDR_STATUS);
    assign mode_chg = wr_ctrl &&
        (in[CTRL_MODE_LSB +: CTRL_MODE_W] != mode);

    // A register write in the same cycle always beats the tick.
    assign tick_ok = tick & ~any_wr;

    assign pat_led       = pattern[NLED-1:0];
    assign unused_pat_hi = ^pattern;
    assign status        = {chase, phase};

    led_prescaler #(.W(16)) u_presc (
        .clk    (clk),
        .reset  (reset),
        .clear  (wr_per | mode_chg),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= '0;
            period  <= DEFAULT_PERIOD;
        end else begin
            if (wr_pat) pattern <= in;
            if (wr_per) period  <= in;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty    <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (wr_ctrl) duty <= in[CTRL_DUTY_LSB +: PWM_BITS];
        end
    end
`else
    assign duty = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode  <= MODE_STATIC;
            phase <= PHASE_ON;
            chase <= '0;
            led   <= '0;
        end else begin
            mode  <= mode_nx;
            phase <= phase_nx;
            chase <= chase_nx;
            led   <= led_nx;
        end
    end

    always_comb begin
        mode_nx  = mode;
        phase_nx = phase;
        chase_nx = chase;
        led_nx   = pat_led;
        if (wr_ctrl) begin
            mode_nx = mode_e'(in[CTRL_MODE_LSB +: CTRL_MODE_W]);
        end
        unique case (mode)
            MODE_BLINK: begin
                led_nx = (phase == PHASE_ON) ? pat_led : '0;
                if (tick_ok) phase_nx = ~phase;
            end
            MODE_CHASE: begin
                led_nx = chase;
                if (wr_pat) begin
                    chase_nx = in[NLED-1:0];
                end else if (tick_ok) begin
                    chase_nx = (chase << 1) | (chase >> (NLED - 1));
                end
            end
            MODE_PWM: begin
`ifdef LED_PWM_EN
                led_nx = (pwm_cnt < duty) ? pat_led : '0;
`else
                led_nx = pat_led;
`endif
            end
            default: begin
                led_nx = pat_led;
            end
        endcase
        if (mode_chg) begin
            phase_nx = PHASE_ON;
            chase_nx = pat_led;
        end
    end

    always_comb begin
        out = '0;
        case (addr)
            ADDR_PATTERN: out = 16'(pat_led);
            ADDR_CTRL: begin
                out[CTRL_MODE_LSB +: CTRL_MODE_W] = mode;
                out[CTRL_DUTY_LSB +: PWM_BITS]    = duty;
            end
            ADDR_PERIOD: out = period;
            default:     out = 16'(status);
        endcase
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl (NLED=8, PWM_BITS=8).
// Honours LED_PWM_EN the same way the design does.
module tb_led_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  addr = 2'd1;
    logic [15:0] in = 16'h0;
    logic [15:0] out;
    logic [7:0]  led;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_ctrl #(
        .NLED(8),
        .DEFAULT_PERIOD(16'd50000),
        .PWM_BITS(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .addr  (addr),
        .in    (in),
        .out   (out),
        .led   (led)
    );

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: register map plus mode rules.
    logic [15:0] m_pat, m_period;
    logic [1:0]  m_mode;
    logic [7:0]  m_duty, m_chase, m_led;
    logic        m_phase;
    int          m_since, m_pwm;

    function automatic logic [15:0] m_out(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, m_pat[7:0]};
            2'd1:    return {6'b0, m_duty, m_mode};
            2'd2:    return m_period;
            default: return {7'b0, m_chase, m_phase};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pat <= 0; m_period <= 16'd50000; m_mode <= 0;
            m_duty <= 0; m_chase <= 0; m_led <= 0;
            m_phase <= 1'b1; m_since <= 0; m_pwm <= 0;
        end else begin : step
            automatic int eff = (m_period == 0) ? 1 : int'(m_period);
            automatic bit tick = ((m_since + 1) % eff) == 0;
            automatic bit wr = load && addr != 2'd3;
            automatic bit chg = load && addr == 2'd1 && in[1:0] != m_mode;
            automatic logic [7:0] pl = m_pat[7:0];
            case (m_mode)
                2'd1: m_led <= m_phase ? pl : 8'h00;
                2'd2: m_led <= m_chase;
`ifdef LED_PWM_EN
                2'd3: m_led <= (m_pwm < int'(m_duty)) ? pl : 8'h00;
`endif
                default: m_led <= pl;
            endcase
            m_pwm <= (m_pwm + 1) % 256;
            if (load && addr == 2'd0) m_pat <= in;
            if (load && addr == 2'd1) begin
                m_mode <= in[1:0];
`ifdef LED_PWM_EN
                m_duty <= in[9:2];
`endif
            end
            if (load && addr == 2'd2) begin
                m_period <= in;
                m_since  <= 0;
            end else if (chg) m_since <= 0;
            else m_since <= m_since + 1;
            if (chg) begin
                m_phase <= 1'b1;
                m_chase <= pl;
            end else begin
                if (m_mode == 2'd1 && tick && !wr) m_phase <= ~m_phase;
                if (m_mode == 2'd2) begin
                    if (load && addr == 2'd0) m_chase <= in[7:0];
                    else if (tick && !wr)
                        m_chase <= {m_chase[6:0], m_chase[7]};
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_led", {8'h00, led}, {8'h00, m_led});
        check("model_out", out, m_out(addr));
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk); #2;
        load = 1'b1; addr = a; in = d;
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string name,
                      input logic [15:0] exp);
        @(posedge clk); #2;
        addr = a;
        #1 check(name, out, exp);
    endtask

    logic [7:0] s [0:15];
    logic [7:0] chase_exp [0:8];
    int lit;
    bit found;

    initial begin
        chase_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18,
                      8'h30, 8'h60, 8'hC0, 8'h81};
        #1 reset = 1'b1;
        #3 check("rst_led", {8'h00, led}, 16'h0000);
        check("rst_ctrl", out, 16'h0000);
        @(posedge clk); #2 reset = 1'b0;
        rd(2'd1, "rst_ctrl2", 16'h0000);
        rd(2'd2, "rst_period", 16'd50000);
        rd(2'd3, "rst_status", 16'h0001);

        wr(2'd0, 16'h00A5);
        @(negedge clk) check("static_edge_k", {8'h00, led}, 16'h0000);
        @(negedge clk) check("static_edge_k1", {8'h00, led}, 16'h00A5);
        rd(2'd0, "pattern_rb", 16'h00A5);

        wr(2'd0, 16'hABCD);
        rd(2'd0, "pattern_mask", 16'h00CD);
        check("led_mask", {8'h00, led}, 16'h00CD);
        wr(2'd3, 16'hFFFF);
        rd(2'd3, "status_ro", 16'h0001);

        wr(2'd0, 16'h000F);
        wr(2'd2, 16'd4);
        wr(2'd1, 16'h0001);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk) s[i] = led;
        end
        check("blink_s4", {8'h00, s[4]}, 16'h000F);
        check("blink_s5", {8'h00, s[5]}, 16'h0000);
        check("blink_s8", {8'h00, s[8]}, 16'h0000);
        check("blink_s9", {8'h00, s[9]}, 16'h000F);
        check("blink_s12", {8'h00, s[12]}, 16'h000F);

        wr(2'd2, 16'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) s[i] = led;
        end
        check("blink_fast_a", {8'h00, s[1] ^ s[2]}, 16'h000F);
        check("blink_fast_b", {8'h00, s[2] ^ s[3]}, 16'h000F);

        wr(2'd0, 16'h0081);
        wr(2'd2, 16'd1);
        wr(2'd1, 16'h0002);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk) check("chase_seq", {8'h00, led},
                                 {8'h00, chase_exp[i]});
        end
        wr(2'd0, 16'h0011);
        @(negedge clk);
        @(negedge clk) check("chase_reload", {8'h00, led}, 16'h0011);
        @(negedge clk) check("chase_after", {8'h00, led}, 16'h0022);

        wr(2'd0, 16'h00FF);
        wr(2'd1, 16'h0103);
`ifdef LED_PWM_EN
        rd(2'd1, "ctrl_rb", 16'h0103);
`else
        rd(2'd1, "ctrl_rb", 16'h0003);
`endif
        @(negedge clk);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk) if (led == 8'hFF) lit++;
        end
`ifdef LED_PWM_EN
        check("pwm64_lit", 16'(lit), 16'd64);
`else
        check("pwm64_lit", 16'(lit), 16'd256);
`endif
        wr(2'd1, 16'h0003);
        @(negedge clk);
        @(negedge clk);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk) if (led == 8'hFF) lit++;
        end
`ifdef LED_PWM_EN
        check("pwm0_lit", 16'(lit), 16'd0);
`else
        check("pwm0_lit", 16'(lit), 16'd256);
`endif

        wr(2'd2, 16'd2);
        wr(2'd1, 16'h0001);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk) found = (led != 8'h00);
        end
        check("blink_lit", {8'h00, led}, 16'h00FF);
        #3 reset = 1'b1;
        #1 check("async_rst_led", {8'h00, led}, 16'h0000);
        @(posedge clk); #2 reset = 1'b0;
        rd(2'd1, "post_rst_ctrl", 16'h0000);
        check("post_rst_led", {8'h00, led}, 16'h0000);
        rd(2'd2, "post_rst_period", 16'd50000);
        @(negedge clk) check("post_rst_led2", {8'h00, led}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
